mdu_hilo: RTL

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS32 core. It executes MULT, MULTU, DIV and DIVU iteratively at one bit per cycle. It also services MTHI and MTLO. It drives `hi` and `lo` into the 32-bit 4:1 writeback select, where `hi` and `lo` serve MFHI and MFLO alongside the ALU result and memory data.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_hilo.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// iteration count and the conditional two's-complement helper.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int MDU_ITERS = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Negate v (two's complement) when neg is set. Operates at 64 bits; 32-bit
  // callers zero-extend and keep the low half, which is the 32-bit negation.
  function automatic logic [63:0] cneg(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_hilo.sv
// Iterative MIPS32 multiply/divide unit with architectural HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide, then a sign fixup
// cycle. HI/LO only change on MTHI/MTLO in IDLE or at operation completion.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int DW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [4:0]       count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic             sign_a_q, sign_a_d;   // dividend / multiplicand negative (signed ops only)
  logic             sign_b_q, sign_b_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;     // dividend as presented, returned in HI on divide by zero
  logic [WIDTH-1:0] opnd_q, opnd_d;       // multiplicand or divisor magnitude
  logic [DW-1:0]    acc_q, acc_d;         // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // Operand magnitudes at launch; unsigned ops never flag a sign.
  logic             is_signed_in;
  logic             sa_in, sb_in;
  logic [DW-1:0]    amag_w, bmag_w;

  assign is_signed_in = ~op[0];
  assign sa_in        = is_signed_in & a[WIDTH-1];
  assign sb_in        = is_signed_in & b[WIDTH-1];
  assign amag_w       = cneg({{WIDTH{1'b0}}, a}, sa_in);
  assign bmag_w       = cneg({{WIDTH{1'b0}}, b}, sb_in);

  // One iteration of each algorithm, computed from the current accumulator.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem_s;
  logic [WIDTH:0]   div_diff;

  assign mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign div_rem_s = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_rem_s - {1'b0, opnd_q};

  // Sign-corrected results used in the FIX cycle.
  logic [DW-1:0]    prod_fix;
  logic [DW-1:0]    quo_fix;
  logic [DW-1:0]    rem_fix;

  assign prod_fix = cneg(acc_q, sign_a_q ^ sign_b_q);
  assign quo_fix  = cneg({{WIDTH{1'b0}}, acc_q[WIDTH-1:0]}, sign_a_q ^ sign_b_q);
  assign rem_fix  = cneg({{WIDTH{1'b0}}, acc_q[DW-1:WIDTH]}, sign_a_q);

  // State, datapath and HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dbz_q    <= 1'b0;
      a_raw_q  <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dbz_q    <= dbz_d;
      a_raw_q  <= a_raw_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: launch/MT writes in IDLE, iterate in CALC, commit in FIX.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dbz_d    = dbz_q;
    a_raw_d  = a_raw_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d  = S_CALC;
          count_d  = '0;
          op_d     = op;
          sign_a_d = sa_in;
          sign_b_d = sb_in;
          dbz_d    = (b == '0);
          a_raw_d  = a;
          // Divide iterates over the dividend bits; multiply over the multiplier bits.
          opnd_d   = op[1] ? bmag_w[WIDTH-1:0] : amag_w[WIDTH-1:0];
          acc_d    = {{WIDTH{1'b0}}, (op[1] ? amag_w[WIDTH-1:0] : bmag_w[WIDTH-1:0])};
        end
      end

      S_CALC: begin
        if (op_q[1]) begin
          // Restoring step: keep the trial subtraction only when it stays non-negative.
          if (!div_diff[WIDTH])
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {div_rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'(MDU_ITERS - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        if (!op_q[1]) begin
          hi_d = prod_fix[DW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dbz_q) begin
          hi_d = a_raw_q;
          lo_d = {WIDTH{1'b1}};
        end else begin
          hi_d = rem_fix[WIDTH-1:0];
          lo_d = quo_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule
